// File: rtl/dm_cache_param_if.sv
// Request/response, refill and flush signals of the direct-mapped read cache.
// Latency: none, wires only.
// Backpressure: req_ready from the cache, mem_ack from memory, flush_busy while invalidating.
interface dm_cache_param_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_hit;
    logic [DATA_W-1:0] resp_data;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_data;
    logic              flush;
    logic              flush_busy;

    // Cache side
    modport slave (
        input  req_valid, req_addr, mem_ack, mem_data, flush,
        output req_ready, resp_valid, resp_hit, resp_data, mem_req, mem_addr, flush_busy
    );

    // Requestor / memory / control side
    modport master (
        output req_valid, req_addr, mem_ack, mem_data, flush,
        input  req_ready, resp_valid, resp_hit, resp_data, mem_req, mem_addr, flush_busy
    );
endinterface

// File: rtl/dm_cache_param.sv
// Direct-mapped read-only cache, one word per line, refill from backing memory; optional hit/miss counters under DM_CACHE_STATS_EN.
// Latency: hit response strobe two edges after acceptance; miss adds the refill wait.
// Backpressure: req_ready only in IDLE with flush low; flush takes DEPTH cycles with flush_busy high.
module dm_cache_param #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 4,
    parameter int OFF_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    dm_cache_param_if.slave   bus
`ifdef DM_CACHE_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
`endif
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFF_W;
    localparam int DEPTH = 1 << INDEX_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL,
        RESP,
        FLUSH
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [TAG_W-1:0]   tag_q;
    logic [INDEX_W-1:0] idx_q;
    logic [DEPTH-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_mem  [DEPTH];
    logic [DATA_W-1:0]  data_mem [DEPTH];
    logic [INDEX_W-1:0] flush_idx;

    logic               hit;
    logic               accept;
    logic               refill_done;
    logic               flush_last;
    logic               unused_off;

    // Offset bits only select a byte within the word and play no part in lookup
    assign unused_off  = ^bus.req_addr[OFF_W-1:0];

    assign hit         = valid_q[idx_q] && (tag_mem[idx_q] == tag_q);
    assign accept      = (state == IDLE) && bus.req_valid && bus.req_ready;
    assign refill_done = (state == REFILL) && bus.mem_ack;
    assign flush_last  = (flush_idx == INDEX_W'(DEPTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs; flush wins over a request in IDLE
    always_comb begin
        state_nxt      = state;
        bus.req_ready  = 1'b0;
        bus.flush_busy = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = !bus.flush;
                if (bus.flush) begin
                    state_nxt = FLUSH;
                end else if (bus.req_valid) begin
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                state_nxt = hit ? RESP : REFILL;
            end
            REFILL: begin
                if (bus.mem_ack) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            FLUSH: begin
                bus.flush_busy = 1'b1;
                if (flush_last) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch tag and index of the accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
            idx_q <= '0;
        end else if (accept) begin
            tag_q <= bus.req_addr[ADDR_W-1 -: TAG_W];
            idx_q <= bus.req_addr[OFF_W +: INDEX_W];
        end
    end

    // Refill request: raised on a lookup miss, held stable until mem_ack is sampled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_req  <= 1'b0;
            bus.mem_addr <= '0;
        end else if ((state == LOOKUP) && !hit) begin
            bus.mem_req  <= 1'b1;
            bus.mem_addr <= {tag_q, idx_q, {OFF_W{1'b0}}};
        end else if (refill_done) begin
            bus.mem_req  <= 1'b0;
        end
    end

    // Response capture on entry to RESP; strobe fires on the edge leaving RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.resp_valid <= 1'b0;
            bus.resp_hit   <= 1'b0;
            bus.resp_data  <= '0;
        end else begin
            bus.resp_valid <= (state == RESP);
            if ((state == LOOKUP) && hit) begin
                bus.resp_hit  <= 1'b1;
                bus.resp_data <= data_mem[idx_q];
            end else if (refill_done) begin
                bus.resp_hit  <= 1'b0;
                bus.resp_data <= bus.mem_data;
            end
        end
    end

    // Valid bits: set by refill, cleared one per cycle while flushing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (refill_done) begin
            valid_q[idx_q] <= 1'b1;
        end else if (state == FLUSH) begin
            valid_q[flush_idx] <= 1'b0;
        end
    end

    // Flush walk counter, parked at zero outside FLUSH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_idx <= '0;
        end else if (state == FLUSH) begin
            flush_idx <= flush_last ? '0 : flush_idx + INDEX_W'(1);
        end else begin
            flush_idx <= '0;
        end
    end

    // Tag and data arrays are only written on refill and need no reset
    always_ff @(posedge clk) begin
        if (refill_done) begin
            tag_mem[idx_q]  <= tag_q;
            data_mem[idx_q] <= bus.mem_data;
        end
    end

`ifdef DM_CACHE_STATS_EN
    // Saturating hit/miss counters, cleared when a flush starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if ((state == IDLE) && bus.flush) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == RESP) begin
            if (bus.resp_hit) begin
                if (hit_cnt != 16'hFFFF) begin
                    hit_cnt <= hit_cnt + 16'd1;
                end
            end else begin
                if (miss_cnt != 16'hFFFF) begin
                    miss_cnt <= miss_cnt + 16'd1;
                end
            end
        end
    end
`endif

endmodule
